// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - Store buffer signal bundle: store intake, load lookup, memory drain.
interface store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic [3:0]    st_be;
  logic          st_ready;

  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic [3:0]    ld_be;
  logic          ld_hit;
  logic [31:0]   ld_data;
  logic          ld_stall;

  logic          mem_req;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_data;
  logic [3:0]    mem_be;
  logic          mem_ack;

  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, ld_be, mem_ack,
    input  st_ready, ld_hit, ld_data, ld_stall, mem_req, mem_addr, mem_data, mem_be,
           empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, ld_be, mem_ack,
    output st_ready, ld_hit, ld_data, ld_stall, mem_req, mem_addr, mem_data, mem_be,
           empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - Post-commit store FIFO draining to data memory with store-to-load forwarding.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0] head, tail;
  logic [29:0]   e_addr [DEPTH];
  logic [31:0]   e_data [DEPTH];
  logic [3:0]    e_be   [DEPTH];

  logic [CW-1:0] used;
  logic          full, is_empty, enq, deq;
  logic          unused_low_bits;

  assign unused_low_bits = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

  assign used     = tail - head;
  assign is_empty = (head == tail);
  assign full     = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
  assign enq      = bus.st_valid && !full;
  assign deq      = !is_empty && bus.mem_ack;

  assign bus.st_ready = !full;
  assign bus.empty    = is_empty;
  assign bus.count    = used;
  assign bus.mem_req  = !is_empty;
  assign bus.mem_addr = is_empty ? '0 : {e_addr[head[AW-1:0]], 2'b00};
  assign bus.mem_data = is_empty ? '0 : e_data[head[AW-1:0]];
  assign bus.mem_be   = is_empty ? '0 : e_be[head[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_addr[i] <= '0;
        e_data[i] <= '0;
        e_be[i]   <= '0;
      end
    end else begin
      if (enq) begin
        e_addr[tail[AW-1:0]] <= bus.st_addr[31:2];
        e_data[tail[AW-1:0]] <= bus.st_data;
        e_be[tail[AW-1:0]]   <= bus.st_be;
        tail <= tail + 1'b1;
      end
      if (deq) head <= head + 1'b1;
    end
  end

  logic          y_found, overlap, hit;
  logic [3:0]    y_be;
  logic [31:0]   y_data;
  logic [AW-1:0] idx;
  logic [CW-1:0] age;

  // Walk oldest to youngest so the last match seen is the youngest, independent of wrap.
  always_comb begin
    y_found = 1'b0;
    overlap = 1'b0;
    y_be    = '0;
    y_data  = '0;
    idx     = '0;
    age     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      age = CW'(k);
      idx = head[AW-1:0] + age[AW-1:0];
      if (age < used && e_addr[idx] == bus.ld_addr[31:2]) begin
        y_found = 1'b1;
        y_be    = e_be[idx];
        y_data  = e_data[idx];
        if ((e_be[idx] & bus.ld_be) != 4'h0) overlap = 1'b1;
      end
    end
  end

  assign hit          = bus.ld_valid && y_found && ((y_be & bus.ld_be) == bus.ld_be);
  assign bus.ld_hit   = hit;
  assign bus.ld_stall = bus.ld_valid && !hit && overlap;
  assign bus.ld_data  = hit ? y_data : 32'h0;
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - Directed and random checks of store_buffer against a queue model.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH)) bus ();
  store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    logic [29:0] wa;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [3:0] sb, input logic lv, input logic [31:0] la,
                       input logic [3:0] lb, input logic ack);
    bus.st_valid = sv;
    bus.st_addr  = sa;
    bus.st_data  = sd;
    bus.st_be    = sb;
    bus.ld_valid = lv;
    bus.ld_addr  = la;
    bus.ld_be    = lb;
    bus.mem_ack  = ack;
  endtask

  // Reference lookup: scan youngest first; first match decides hit, any overlapping match stalls.
  task automatic ref_lookup(output logic hit, output logic stall, output logic [31:0] data);
    logic found, ovl;
    hit = 1'b0; stall = 1'b0; data = 32'h0; found = 1'b0; ovl = 1'b0;
    if (bus.ld_valid) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].wa == bus.ld_addr[31:2]) begin
          if (!found && (q[i].be & bus.ld_be) == bus.ld_be) begin
            hit  = 1'b1;
            data = q[i].data;
          end
          found = 1'b1;
          if ((q[i].be & bus.ld_be) != 4'h0) ovl = 1'b1;
        end
      end
      stall = !hit && ovl;
    end
  endtask

  task automatic check_outputs();
    logic        e_hit, e_stall;
    logic [31:0] e_data;
    int          n;
    #1;
    n = q.size();
    ref_lookup(e_hit, e_stall, e_data);
    check("count",    32'(bus.count),    32'(n));
    check("empty",    32'(bus.empty),    32'(n == 0));
    check("st_ready", 32'(bus.st_ready), 32'(n < DEPTH));
    check("mem_req",  32'(bus.mem_req),  32'(n != 0));
    check("mem_addr", bus.mem_addr,      n != 0 ? {q[0].wa, 2'b00} : 32'h0);
    check("mem_data", bus.mem_data,      n != 0 ? q[0].data : 32'h0);
    check("mem_be",   32'(bus.mem_be),   n != 0 ? 32'(q[0].be) : 32'h0);
    check("ld_hit",   32'(bus.ld_hit),   32'(e_hit));
    check("ld_stall", 32'(bus.ld_stall), 32'(e_stall));
    check("ld_data",  bus.ld_data,       e_data);
  endtask

  task automatic clock();
    ent_t e;
    logic do_enq, do_deq;
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else begin
      do_enq = bus.st_valid && (q.size() < DEPTH);
      do_deq = bus.mem_ack && (q.size() > 0);
      e.wa = bus.st_addr[31:2];
      e.data = bus.st_data;
      e.be = bus.st_be;
      if (do_deq) void'(q.pop_front());
      if (do_enq) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic step();
    check_outputs();
    clock();
  endtask

  task automatic idle_ack(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      step();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    clock();
    reset = 1'b0;

    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_outputs();
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_st_ready", 32'(bus.st_ready), 32'd1);

    // First store, visible next cycle
    drive(1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 32'h102, 4'h4, 0);
    check_outputs();
    check("t1_mem_req", 32'(bus.mem_req), 32'd1);
    check("t1_mem_addr", bus.mem_addr, 32'h100);
    check("t1_count", 32'(bus.count), 32'd1);
    check("t1_hit", 32'(bus.ld_hit), 32'd1);
    check("t1_data", bus.ld_data, 32'hDEADBEEF);
    clock();
    idle_ack(1);

    // Youngest match wins
    drive(1, 32'h200, 32'h11111111, 4'hF, 0, 0, 0, 0); step();
    drive(1, 32'h200, 32'h22222222, 4'hF, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 32'h200, 4'hF, 0);
    check_outputs();
    check("t2_data", bus.ld_data, 32'h22222222);
    clock();
    idle_ack(2);

    // Partial overlap
    drive(1, 32'h300, 32'hAAAA5555, 4'h3, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 32'h300, 4'hF, 0);
    check_outputs();
    check("t3_stall", 32'(bus.ld_stall), 32'd1);
    check("t3_hit", 32'(bus.ld_hit), 32'd0);
    clock();
    drive(0, 0, 0, 0, 1, 32'h300, 4'hC, 0); step();
    idle_ack(1);
    drive(0, 0, 0, 0, 1, 32'h300, 4'hF, 0);
    check_outputs();
    check("t3_stall_after", 32'(bus.ld_stall), 32'd0);
    clock();

    // Fill, drop 5th, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h400 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF, 0, 0, 0, 0);
      step();
    end
    drive(1, 32'h4F0, 32'hBADBAD00, 4'hF, 0, 0, 0, 0);
    check_outputs();
    check("t4_full_ready", 32'(bus.st_ready), 32'd0);
    check("t4_full_count", 32'(bus.count), 32'd4);
    clock();
    idle_ack(DEPTH);
    check_outputs();
    check("t4_empty", 32'(bus.empty), 32'd1);

    // Offset the pointers by one, then fill across the wrap
    drive(1, 32'h0, 32'h0, 4'hF, 0, 0, 0, 0); step();
    idle_ack(1);
    drive(1, 32'h500, 32'hA0A0A0A0, 4'hF, 0, 0, 0, 0); step();
    drive(1, 32'h504, 32'hB1B1B1B1, 4'hF, 0, 0, 0, 0); step();
    drive(1, 32'h500, 32'hC2C2C2C2, 4'h3, 0, 0, 0, 0); step();
    drive(1, 32'h500, 32'hD3D3D3D3, 4'hC, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 32'h500, 4'h4, 0);
    check_outputs();
    check("t5_wrap_data", bus.ld_data, 32'hD3D3D3D3);
    clock();
    drive(0, 0, 0, 0, 1, 32'h500, 4'hF, 0); step();
    drive(0, 0, 0, 0, 1, 32'h500, 4'h1, 0); step();
    idle_ack(DEPTH);

    // Steady state: enqueue and dequeue every cycle
    drive(1, 32'h700, 32'h70000000, 4'hF, 0, 0, 0, 0); step();
    drive(1, 32'h704, 32'h70000001, 4'hF, 0, 0, 0, 0); step();
    for (int i = 2; i < 8; i++) begin
      drive(1, 32'h700 + 32'(4 * i), 32'h70000000 + 32'(i), 4'hF, 0, 0, 0, 1);
      check_outputs();
      check("t6_count", 32'(bus.count), 32'd2);
      clock();
    end
    idle_ack(2);

    // Reset mid-drain beats simultaneous store and ack
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h800 + 32'(4 * i), 32'h80000000 + 32'(i), 4'hF, 0, 0, 0, 0);
      step();
    end
    reset = 1'b1;
    drive(1, 32'h900, 32'h90000000, 4'hF, 0, 0, 0, 1);
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 1, 32'h804, 4'hF, 0);
    check_outputs();
    check("t7_mem_req", 32'(bus.mem_req), 32'd0);
    check("t7_count", 32'(bus.count), 32'd0);
    check("t7_ld_hit", 32'(bus.ld_hit), 32'd0);
    clock();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 2) != 0,
            32'h600 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
            $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 1) == 1,
            32'h600 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)),
            $urandom_range(0, 2) == 0);
      step();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Post-commit store buffer between the M1 memory stage and the data memory port. It queues retired stores, drains them in order to data memory over a req/ack handshake, and forwards buffered store data to younger loads. This is store-to-load forwarding: the memory-side counterpart of the register-side store-data forwarding in the hazard logic. When a load only partially overlaps a buffered store, the block raises a stall instead of forwarding.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- st_valid  in  1  M1 presents a committed store this cycle
- st_addr  in  32  store byte address; bits [1:0] are ignored, word granularity
- st_data  in  32  store data, already lane-aligned
- st_be  in  4  store byte enables
- st_ready  out  1  buffer can accept a store (= !full)
- ld_valid  in  1  M1 presents a load lookup this cycle
- ld_addr  in  32  load byte address; bits [1:0] are ignored
- ld_be  in  4  bytes the load needs
- ld_hit  out  1  load fully satisfied from the buffer
- ld_data  out  32  forwarded word; valid when ld_hit
- ld_stall  out  1  partial overlap; load must wait for the drain
- mem_req  out  1  head entry presented to data memory
- mem_addr  out  32  head word address, {addr[31:2],2'b00}
- mem_data  out  32  head data
- mem_be  out  4  head byte enables
- mem_ack  in  1  memory accepted the write this cycle
- empty  out  1  no valid entries
- count  out  $clog2(DEPTH)+1  number of valid entries

## Operation
- Circular FIFO with head and tail pointers. Each pointer is $clog2(DEPTH)+1 bits; the extra MSB is a wrap bit.
  - full = (pointer indices equal) and (wrap bits differ).
  - empty = pointers equal.
- Enqueue occurs when st_valid && st_ready. The entry is written at tail and tail increments. st_valid while full is ignored; the upstream stall is the producer's responsibility.
- Dequeue occurs when mem_req && mem_ack. Head increments. mem_ack while mem_req=0 is ignored.
- mem_req = !empty. mem_addr, mem_data and mem_be come directly from the head entry register and stay stable until the cycle of mem_ack.
- Simultaneous enqueue and dequeue: both take effect and count is unchanged. When full, st_ready stays 0 even if mem_ack arrives in the same cycle (no same-cycle bypass).
- Load lookup is combinational against entries resident at the start of the cycle.
  - It includes the head entry being dequeued this cycle.
  - It excludes the store being enqueued this cycle.
- Lookup rules:
  - Match = valid entry with addr[31:2] == ld_addr[31:2].
  - Y = youngest match, nearest to tail, using wrap-aware age order.
  - If Y exists and (Y.be & ld_be) == ld_be, then ld_hit=1 and ld_data=Y.data.
  - Otherwise, if any match has (be & ld_be) != 0, then ld_stall=1 and ld_hit=0.
  - Otherwise ld_hit=0 and ld_stall=0; the load reads memory.
- ld_hit and ld_stall are forced to 0 when ld_valid=0. ld_data is 0 whenever ld_hit=0.
- ld_hit and ld_stall are never both 1.
- No merging or coalescing: every accepted store produces exactly one memory write, in acceptance order.

## Timing
- Reset values after the clock edge that samples reset=1:
  - Pointers are 0 and all entries are invalid.
  - empty=1, count=0, st_ready=1, mem_req=0.
  - mem_addr, mem_data and mem_be are 0.
  - ld_hit=0 and ld_stall=0.
- Reset mid-drain discards all entries. mem_req falls on the next edge even without mem_ack, and the memory side must drop the outstanding request. Reset has priority over simultaneous st_valid and mem_ack.
- Enqueue-to-visibility latency is 1 cycle: a store accepted on edge N is searchable by loads and drainable (mem_req=1 when previously empty) from cycle N+1.
- Minimum latency from a store on st_* to mem_ack-retire is 2 edges. Throughput is one enqueue plus one dequeue per cycle.
- count and empty update on the same edge as the pointer change. st_ready deasserts in the cycle after the enqueue that fills the buffer.
- Pointer wrap: after DEPTH enqueues, the index returns to 0 and the wrap bit toggles. The age order used for youngest-match must stay correct across wraps.

## Test plan
- Reset, then enqueue addr 0x100, data 0xDEADBEEF, be 4'hF with mem_ack=0 -> next cycle: mem_req=1, mem_addr=0x100, count=1. A load at 0x102 with be 4'h4 -> ld_hit=1, ld_data=0xDEADBEEF.
- Enqueue 0x200/0x11111111/4'hF, then 0x200/0x22222222/4'hF. A load at 0x200 with be 4'hF -> ld_hit=1, ld_data=0x22222222, the youngest entry.
- Buffer holds 0x300/be 4'h3. Load 0x300 with be 4'hF -> ld_stall=1, ld_hit=0. Load 0x300 with be 4'hC -> both outputs 0. After mem_ack, load 0x300 with be 4'hF -> both outputs 0.
- Fill 4 entries with mem_ack=0 -> st_ready=0, count=4. A 5th st_valid is dropped. Then assert mem_ack for 4 cycles -> writes appear in order and empty=1. Repeat the fill across the pointer wrap; the youngest-match rule still holds.
- Hold st_valid and mem_ack every cycle with count=2 -> count stays 2 and one write retires per cycle.
- Count=3 with mem_req=1, then assert reset for one cycle -> next cycle: mem_req=0, count=0, empty=1, st_ready=1. A load to a previously buffered address -> ld_hit=0.
